mesi_isc_broad_req_queue: RTL and testbench

- Broadcast request queue directly upstream of the broadcast controller.
- Accepts one broadcast entry per cycle from the bus-request arbiter: type, initiator CPU ID and broadcast ID.
- Presents the oldest entry show-ahead on its outputs, with empty/full status; the controller pops it with a one-cycle read pulse.
- Also raises sticky overflow/underflow error flags for debug.

---
 rtl/mesi_isc_broad_pkg.sv | 19 +
 rtl/mesi_isc_wrap_ptr.sv | 26 ++
 rtl/mesi_isc_broad_req_queue.sv | 120 ++++++++++++
 tb/tb_mesi_isc_broad_req_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mesi_isc_broad_pkg.sv
// Shared types for the broadcast path: queue entry layout and breq type codes.
// Field widths here must match the queue's BROAD_TYPE_WIDTH / BROAD_ID_WIDTH defaults.
package mesi_isc_broad_pkg;

  localparam int BREQ_TYPE_W = 2;
  localparam int BREQ_CPU_W  = 2;
  localparam int BREQ_ID_W   = 5;

  localparam logic [BREQ_TYPE_W-1:0] BREQ_TYPE_NOP = 2'd0;
  localparam logic [BREQ_TYPE_W-1:0] BREQ_TYPE_WR  = 2'd1;
  localparam logic [BREQ_TYPE_W-1:0] BREQ_TYPE_RD  = 2'd2;

  typedef struct packed {
    logic [BREQ_TYPE_W-1:0] btype;
    logic [BREQ_CPU_W-1:0]  cpu_id;
    logic [BREQ_ID_W-1:0]   id;
  } broad_entry_t;

endpackage

// File: rtl/mesi_isc_wrap_ptr.sv
// Wrapping pointer register with increment enable; wraps naturally at 2**WIDTH-1 -> 0.
module mesi_isc_wrap_ptr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/mesi_isc_broad_req_queue.sv
// Broadcast request FIFO with show-ahead head, occupancy status and sticky error flags.
// Optional high-water mark output hwm_o when MESI_ISC_BROAD_QUEUE_HWM_EN is defined.
module mesi_isc_broad_req_queue
  import mesi_isc_broad_pkg::*;
#(
  parameter int DEPTH            = 4,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_i,
  input  logic [BROAD_TYPE_WIDTH-1:0]   wr_type_i,
  input  logic [1:0]                    wr_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]     wr_id_i,
  input  logic                          rd_i,
  output logic [BROAD_TYPE_WIDTH-1:0]   broad_snoop_type_o,
  output logic [1:0]                    broad_snoop_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]     broad_snoop_id_o,
  output logic                          fifo_status_empty_o,
  output logic                          fifo_status_full_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          overflow_err_o,
  output logic                          underflow_err_o
`ifdef MESI_ISC_BROAD_QUEUE_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]    hwm_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  broad_entry_t   mem_q [DEPTH];
  broad_entry_t   wr_entry;
  broad_entry_t   head;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic           overflow_q;
  logic           underflow_q;
  logic           empty;
  logic           full;
  logic           push_acc;
  logic           pop_acc;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  // A full queue still accepts a push when the same cycle frees a slot.
  assign push_acc = wr_i && (!full || rd_i);
  assign pop_acc  = rd_i && !empty;

  mesi_isc_wrap_ptr #(.WIDTH(PW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (push_acc),
    .ptr_o (wr_ptr)
  );

  mesi_isc_wrap_ptr #(.WIDTH(PW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pop_acc),
    .ptr_o (rd_ptr)
  );

  assign wr_entry.btype  = wr_type_i;
  assign wr_entry.cpu_id = wr_cpu_id_i;
  assign wr_entry.id     = wr_id_i;

  always_ff @(posedge clk) begin
    if (rst && push_acc) mem_q[wr_ptr] <= wr_entry;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_i && full && !rd_i) overflow_q  <= 1'b1;
      if (rd_i && empty)         underflow_q <= 1'b1;
    end
  end

`ifdef MESI_ISC_BROAD_QUEUE_HWM_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clk) begin
    if (!rst)                 hwm_q <= '0;
    else if (count_q > hwm_q) hwm_q <= count_q;
  end

  assign hwm_o = hwm_q;
`endif

  // Stale storage must never leak out while the queue is empty.
  assign head = empty ? '0 : mem_q[rd_ptr];

  assign broad_snoop_type_o   = head.btype;
  assign broad_snoop_cpu_id_o = head.cpu_id;
  assign broad_snoop_id_o     = head.id;
  assign fifo_status_empty_o  = empty;
  assign fifo_status_full_o   = full;
  assign count_o              = count_q;
  assign overflow_err_o       = overflow_q;
  assign underflow_err_o      = underflow_q;

endmodule

// File: tb/tb_mesi_isc_broad_req_queue.sv
// Directed bench for mesi_isc_broad_req_queue (DEPTH=4); hwm_o checked when MESI_ISC_BROAD_QUEUE_HWM_EN is defined.
module tb_mesi_isc_broad_req_queue;
  import mesi_isc_broad_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_i;
  logic [1:0] wr_type_i;
  logic [1:0] wr_cpu_id_i;
  logic [4:0] wr_id_i;
  logic       rd_i;
  logic [1:0] snoop_type;
  logic [1:0] snoop_cpu;
  logic [4:0] snoop_id;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       ovf;
  logic       unf;
`ifdef MESI_ISC_BROAD_QUEUE_HWM_EN
  logic [2:0] hwm;
`endif

  int total = 0;
  int bad   = 0;
  logic [8:0] q[$];
  logic [8:0] e;

  always #5 clk = ~clk;

  mesi_isc_broad_req_queue #(.DEPTH(4), .BROAD_TYPE_WIDTH(2), .BROAD_ID_WIDTH(5)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wr_i                 (wr_i),
    .wr_type_i            (wr_type_i),
    .wr_cpu_id_i          (wr_cpu_id_i),
    .wr_id_i              (wr_id_i),
    .rd_i                 (rd_i),
    .broad_snoop_type_o   (snoop_type),
    .broad_snoop_cpu_id_o (snoop_cpu),
    .broad_snoop_id_o     (snoop_id),
    .fifo_status_empty_o  (empty),
    .fifo_status_full_o   (full),
    .count_o              (count),
    .overflow_err_o       (ovf),
    .underflow_err_o      (unf)
`ifdef MESI_ISC_BROAD_QUEUE_HWM_EN
    ,
    .hwm_o                (hwm)
`endif
  );

  function automatic logic [8:0] ent(input logic [1:0] t, input logic [1:0] c, input logic [4:0] i);
    return {t, c, i};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic [8:0] ev, input logic r);
    wr_i        = w;
    wr_type_i   = ev[8:7];
    wr_cpu_id_i = ev[6:5];
    wr_id_i     = ev[4:0];
    rd_i        = r;
    @(posedge clk);
    #1;
    wr_i = 1'b0;
    rd_i = 1'b0;
    $display("step wr=%0b rd=%0b in=%h -> head=%h cnt=%0d e=%0b f=%0b ovf=%0b unf=%0b",
             w, r, ev, {snoop_type, snoop_cpu, snoop_id}, count, empty, full, ovf, unf);
  endtask

  function automatic logic [8:0] head();
    return {snoop_type, snoop_cpu, snoop_id};
  endfunction

  initial begin
    rst = 1'b0; wr_i = 1'b0; rd_i = 1'b0;
    wr_type_i = '0; wr_cpu_id_i = '0; wr_id_i = '0;
    step(0, 9'h0, 0);
    step(0, 9'h0, 0);
    rst = 1'b1;
    step(0, 9'h0, 0);

    // Reset state
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full),  0);
    chk("rst_count", 32'(count), 0);
    chk("rst_head",  32'(head()), 0);
    chk("rst_ovf",   32'(ovf),   0);
    chk("rst_unf",   32'(unf),   0);
`ifdef MESI_ISC_BROAD_QUEUE_HWM_EN
    chk("rst_hwm",   32'(hwm),   0);
`endif

    // Two pushes, head stays on the first, then two pops
    step(1, ent(BREQ_TYPE_WR, 2'd2, 5'd5), 0);
    chk("p1_head",  32'(head()), 32'(9'b01_10_00101));
    chk("p1_empty", 32'(empty), 0);
    chk("p1_count", 32'(count), 1);
    step(1, ent(BREQ_TYPE_RD, 2'd0, 5'd9), 0);
    chk("p2_head",  32'(head()), 32'(9'b01_10_00101));
    chk("p2_count", 32'(count), 2);
    step(0, 9'h0, 0);
    chk("idle_head", 32'(head()), 32'(9'b01_10_00101));
    step(0, 9'h0, 1);
    chk("pop1_head",  32'(head()), 32'(9'b10_00_01001));
    chk("pop1_count", 32'(count), 1);
    step(0, 9'h0, 1);
    chk("pop2_empty", 32'(empty), 1);
    chk("pop2_head",  32'(head()), 0);
    chk("pop2_count", 32'(count), 0);
    chk("pop2_unf",   32'(unf), 0);

    // Fill to DEPTH, then a dropped push
    for (int k = 1; k <= 4; k++) begin
      e = ent(2'(k), 2'(k + 1), 5'(k));
      q.push_back(e);
      step(1, e, 0);
      chk("fill_count", 32'(count), 32'(k));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_head", 32'(head()), 32'(9'b01_10_00001));
    chk("pre_ovf",   32'(ovf), 0);
    step(1, ent(2'd3, 2'd3, 5'd31), 0);
    chk("ovf_flag",  32'(ovf), 1);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_head",  32'(head()), 32'(9'b01_10_00001));

    // Push+pop while full, across pointer wrap
    for (int k = 5; k <= 10; k++) begin
      e = ent(2'(k), 2'(k + 3), 5'(k + 10));
      void'(q.pop_front());
      q.push_back(e);
      step(1, e, 1);
      chk("pp_count", 32'(count), 4);
      chk("pp_full",  32'(full), 1);
      chk("pp_head",  32'(head()), 32'(q[0]));
    end

    // Drain in FIFO order
    for (int k = 0; k < 4; k++) begin
      chk("drain_head", 32'(head()), 32'(q[0]));
      void'(q.pop_front());
      step(0, 9'h0, 1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_head0", 32'(head()), 0);
    chk("drain_unf",   32'(unf), 0);

    // Reset clears sticky errors; push+pop while empty
    rst = 1'b0;
    step(0, 9'h0, 0);
    rst = 1'b1;
    chk("clr_ovf", 32'(ovf), 0);
    step(1, ent(2'd2, 2'd3, 5'd17), 1);
    chk("pe_unf",   32'(unf), 1);
    chk("pe_count", 32'(count), 1);
    chk("pe_head",  32'(head()), 32'(9'b10_11_10001));
    step(0, 9'h0, 1);
    chk("pe_pop_count", 32'(count), 0);
    step(0, 9'h0, 1);
    chk("pop_empty_unf",   32'(unf), 1);
    chk("pop_empty_count", 32'(count), 0);

    // Fill 3, then reset with a concurrent push
    rst = 1'b0;
    step(0, 9'h0, 0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) step(1, ent(2'd1, 2'(k), 5'(k + 20)), 0);
    step(0, 9'h0, 0);
    chk("f3_count", 32'(count), 3);
`ifdef MESI_ISC_BROAD_QUEUE_HWM_EN
    chk("f3_hwm", 32'(hwm), 3);
`endif
    rst = 1'b0;
    step(1, ent(2'd3, 2'd1, 5'd7), 0);
    chk("mr_count", 32'(count), 0);
    chk("mr_empty", 32'(empty), 1);
    chk("mr_head",  32'(head()), 0);
    chk("mr_unf",   32'(unf), 0);
`ifdef MESI_ISC_BROAD_QUEUE_HWM_EN
    chk("mr_hwm", 32'(hwm), 0);
`endif
    rst = 1'b1;
    step(0, 9'h0, 0);
    chk("post_rst_empty", 32'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
